// File: rtl/riscv_hazard_pkg.sv
// Shared encodings and defaults for the hazard/forwarding unit.
// Optional perf counters are enabled in the top level by defining HAZARD_PERF_CNT_EN.
package riscv_hazard_pkg;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_LOADUSE = 2'd1,
        CAUSE_SB      = 2'd2,
        CAUSE_STRUCT  = 2'd3
    } stall_cause_e;

    localparam int unsigned FWD_SEL_RF       = 0;
    localparam int unsigned LONG_LAT_DEFAULT = 4;
    localparam int unsigned NUM_REGS         = 32;

    function automatic int unsigned cnt_width(input int unsigned lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register busy counters for the fixed-latency long unit (x1..x31) plus the
// non-pipelined unit's own busy counter.
module hazard_scoreboard
    import riscv_hazard_pkg::*;
#(
    parameter int unsigned LONG_LAT = LONG_LAT_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue,
    input  logic [4:0]          issue_rd,
    input  logic                issue_regwrite,
    output logic [NUM_REGS-1:0] busy,
    output logic                long_busy
);

    localparam int unsigned      CNT_W    = cnt_width(LONG_LAT);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LONG_LAT);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [1:NUM_REGS-1];
    logic [CNT_W-1:0] cnt_d [1:NUM_REGS-1];
    logic [CNT_W-1:0] long_cnt_q;
    logic [CNT_W-1:0] long_cnt_d;

    // A load on issue takes precedence over the decrement of the same counter.
    always_comb begin
        for (int r = 1; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (issue && issue_regwrite && (issue_rd == 5'(r))) begin
                cnt_d[r] = LOAD_VAL;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - ONE;
            end
        end
    end

    always_comb begin
        long_cnt_d = long_cnt_q;
        if (issue) begin
            long_cnt_d = LOAD_VAL;
        end else if (long_cnt_q != '0) begin
            long_cnt_d = long_cnt_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            long_cnt_q <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            long_cnt_q <= long_cnt_d;
        end
    end

    // Count 1 is the write-back cycle; the register file writes through to the
    // ID read, so the dependant is released there (busy window LONG_LAT-1).
    always_comb begin
        busy = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            busy[r] = (cnt_q[r] > ONE);
        end
    end

    assign long_busy = (long_cnt_q != '0);

endmodule

// File: rtl/hazard_forward_scoreboard.sv
// Bypass select generation, load-use / scoreboard / structural stall logic.
// Define HAZARD_PERF_CNT_EN to add saturating per-cause stall counters.
module hazard_forward_scoreboard
    import riscv_hazard_pkg::*;
#(
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned NUM_FWD  = 2,
    parameter int unsigned LONG_LAT = LONG_LAT_DEFAULT,
    parameter int unsigned SEL_W    = $clog2(NUM_FWD + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     id_valid,
    input  logic [5*NUM_SRC-1:0]     id_rs,
    input  logic [NUM_SRC-1:0]       id_rs_used,
    input  logic [4:0]               id_rd,
    input  logic                     id_regwrite,
    input  logic                     id_is_long,
    input  logic                     ex_valid,
    input  logic                     ex_regwrite,
    input  logic                     ex_is_load,
    input  logic [4:0]               ex_rd,
    input  logic [5*NUM_SRC-1:0]     ex_rs,
    input  logic [NUM_FWD-1:0]       stg_regwrite,
    input  logic [5*NUM_FWD-1:0]     stg_rd,
    input  logic [NUM_FWD-1:0]       stg_fwd_ok,
    input  logic                     flush,
    output logic [SEL_W*NUM_SRC-1:0] fwd_sel,
    output logic                     stall,
    output logic [1:0]               stall_cause
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]              perf_loaduse,
    output logic [31:0]              perf_sb,
    output logic [31:0]              perf_struct
`endif
);

    logic [NUM_REGS-1:0] busy;
    logic                long_busy;
    logic                load_use;
    logic                sb_hit;
    logic                struct_hit;
    logic                issue;
    stall_cause_e        cause;

    // Scan oldest to youngest so the youngest matching stage overwrites last.
    always_comb begin
        fwd_sel = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            fwd_sel[SEL_W*s +: SEL_W] = SEL_W'(FWD_SEL_RF);
            for (int k = NUM_FWD; k >= 1; k--) begin
                if (stg_regwrite[k-1] && stg_fwd_ok[k-1] &&
                    (stg_rd[5*(k-1) +: 5] == ex_rs[5*s +: 5]) &&
                    (ex_rs[5*s +: 5] != 5'd0)) begin
                    fwd_sel[SEL_W*s +: SEL_W] = SEL_W'(k);
                end
            end
        end
    end

    always_comb begin
        load_use = 1'b0;
        if (id_valid && ex_valid && ex_regwrite && ex_is_load && (ex_rd != 5'd0)) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (id_rs_used[s] && (id_rs[5*s +: 5] == ex_rd)) begin
                    load_use = 1'b1;
                end
            end
        end
    end

    // busy[0] is tied low, so x0 sources/destinations never hazard.
    always_comb begin
        sb_hit = id_regwrite && busy[id_rd];
        for (int s = 0; s < NUM_SRC; s++) begin
            if (id_rs_used[s] && busy[id_rs[5*s +: 5]]) begin
                sb_hit = 1'b1;
            end
        end
    end

    assign struct_hit = id_is_long && long_busy;
    assign stall      = id_valid && !flush && (load_use || sb_hit || struct_hit);
    assign issue      = id_valid && !stall && !flush && id_is_long;

    always_comb begin
        cause = CAUSE_NONE;
        if (stall) begin
            if (load_use) begin
                cause = CAUSE_LOADUSE;
            end else if (sb_hit) begin
                cause = CAUSE_SB;
            end else begin
                cause = CAUSE_STRUCT;
            end
        end
    end

    assign stall_cause = cause;

    hazard_scoreboard #(
        .LONG_LAT (LONG_LAT)
    ) u_scoreboard (
        .clk            (clk),
        .reset          (reset),
        .issue          (issue),
        .issue_rd       (id_rd),
        .issue_regwrite (id_regwrite),
        .busy           (busy),
        .long_busy      (long_busy)
    );

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_lu_q, perf_lu_d;
    logic [31:0] perf_sb_q, perf_sb_d;
    logic [31:0] perf_st_q, perf_st_d;

    always_comb begin
        perf_lu_d = perf_lu_q;
        perf_sb_d = perf_sb_q;
        perf_st_d = perf_st_q;
        if ((cause == CAUSE_LOADUSE) && (perf_lu_q != '1)) perf_lu_d = perf_lu_q + 32'd1;
        if ((cause == CAUSE_SB) && (perf_sb_q != '1))      perf_sb_d = perf_sb_q + 32'd1;
        if ((cause == CAUSE_STRUCT) && (perf_st_q != '1))  perf_st_d = perf_st_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_lu_q <= '0;
            perf_sb_q <= '0;
            perf_st_q <= '0;
        end else begin
            perf_lu_q <= perf_lu_d;
            perf_sb_q <= perf_sb_d;
            perf_st_q <= perf_st_d;
        end
    end

    assign perf_loaduse = perf_lu_q;
    assign perf_sb      = perf_sb_q;
    assign perf_struct  = perf_st_q;
`endif

endmodule
